// File: rtl/ram_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_step_ctrl_if
// Description : RAM port bundle between the step sequencer (master) and a
//               synchronous single-port RAM (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface ram_step_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport master (
        output ram_addr_o,
        output ram_we_o,
        output ram_wdata_o,
        input  ram_rdata_i
    );

    modport slave (
        input  ram_addr_o,
        input  ram_we_o,
        input  ram_wdata_o,
        output ram_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/ram_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_step_ctrl
// Description : Slow-rate RAM sequencer. Advances one RAM word per rising
//               edge of the divided clock level step_i, either filling the
//               RAM with base+addr or scanning it out with a valid strobe.
// Revision    : 1.0  initial release
// ============================================================================
module ram_step_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  wire                 clk_i,
    input  wire                 rst_ni,
    input  wire                 step_i,
    input  wire                 start_i,
    input  wire                 abort_i,
    input  wire                 mode_i,
    input  wire  [DATA_W-1:0]   wdata_i,
    ram_step_ctrl_if.master     ram,
    output logic [DATA_W-1:0]   data_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0]        c_IDLE      = 3'd0;
    localparam logic [2:0]        c_RUN       = 3'd1;
    localparam logic [2:0]        c_WR        = 3'd2;
    localparam logic [2:0]        c_RD        = 3'd3;
    localparam logic [2:0]        c_DONE      = 3'd4;
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_step_q;
    logic              r_mode;
    logic [DATA_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_tick;
    logic              w_last;
    logic [DATA_W-1:0] w_addr_ext;

    // Reset level of 1 matches the divider, so release never looks like a rise.
    assign w_tick     = step_i & ~r_step_q;
    assign w_last     = (r_addr == c_ADDR_LAST);
    assign w_addr_ext = DATA_W'(r_addr);

    // Delay the step level by one cycle for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_step_q <= 1'b1;
        end else begin
            r_step_q <= step_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort returns to IDLE from any busy state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i && !abort_i) begin
                    w_next = c_RUN;
                end
            end
            c_RUN: begin
                if (abort_i) begin
                    w_next = c_IDLE;
                end else if (w_tick) begin
                    w_next = r_mode ? c_WR : c_RD;
                end
            end
            c_WR, c_RD: begin
                if (abort_i) begin
                    w_next = c_IDLE;
                end else if (w_last) begin
                    w_next = c_DONE;
                end else begin
                    w_next = c_RUN;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy_o = (r_state != c_IDLE);
        done_o = (r_state == c_DONE);
    end

    // Datapath: address walk, write pulse and read capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode  <= 1'b0;
            r_base  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            // Write enable and valid are single-cycle pulses by default.
            r_we    <= 1'b0;
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_i && !abort_i) begin
                        r_mode <= mode_i;
                        r_base <= wdata_i;
                        r_addr <= '0;
                    end
                end
                c_RUN: begin
                    if (abort_i) begin
                        r_addr <= '0;
                    end else if (w_tick && r_mode) begin
                        r_we    <= 1'b1;
                        r_wdata <= r_base + w_addr_ext;
                    end
                end
                c_WR: begin
                    if (abort_i) begin
                        r_addr <= '0;
                    end else if (!w_last) begin
                        r_addr <= r_addr + c_ADDR_ONE;
                    end
                end
                c_RD: begin
                    // Read data for the address held since the tick is valid now.
                    if (abort_i) begin
                        r_addr <= '0;
                    end else begin
                        r_data  <= ram.ram_rdata_i;
                        r_valid <= 1'b1;
                        if (!w_last) begin
                            r_addr <= r_addr + c_ADDR_ONE;
                        end
                    end
                end
                default: begin
                    r_addr <= '0;
                end
            endcase
        end
    end

    assign ram.ram_addr_o  = r_addr;
    assign ram.ram_we_o    = r_we;
    assign ram.ram_wdata_o = r_wdata;
    assign data_o          = r_data;
    assign valid_o         = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_step_ctrl
// Description : Self-checking bench for ram_step_ctrl with a RAM model and an
//               event-level reference model (expected write/valid/done cycles).
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ram_step_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int NW     = 16;

    logic        clk     = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        step_i  = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        mode_i  = 1'b0;
    logic [7:0]  wdata_i = 8'h00;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        preload = 1'b0;

    ram_step_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

    ram_step_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .step_i  (step_i),
        .start_i (start_i),
        .abort_i (abort_i),
        .mode_i  (mode_i),
        .wdata_i (wdata_i),
        .ram     (ram_bus),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle synchronous read, write on we.
    logic [7:0] mem [NW];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NW; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (ram_bus.ram_we_o) begin
            mem[ram_bus.ram_addr_o] <= ram_bus.ram_wdata_o;
        end
        ram_bus.ram_rdata_i <= mem[ram_bus.ram_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events: kind 1 = write pulse, 2 = valid strobe, 3 = done pulse.
    typedef struct packed {
        int         c;
        logic [1:0] k;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t obs[$];
    ev_t expq[$];
    int  rises[$];
    logic [7:0] ref_mem [NW];
    int  n_vec = 0;
    int  n_err = 0;

    always @(negedge clk) begin
        if (ram_bus.ram_we_o) obs.push_back('{cyc, 2'd1, {4'b0, ram_bus.ram_addr_o}, ram_bus.ram_wdata_o});
        if (valid_o)          obs.push_back('{cyc, 2'd2, 8'h00, data_o});
        if (done_o)           obs.push_back('{cyc, 2'd3, 8'h00, 8'h00});
    end

    function automatic string ev_str(input ev_t e);
        return $sformatf("c=%0d k=%0d a=%h d=%h", e.c, e.k, e.a, e.d);
    endfunction

    // Reference model: word i ticks at rises[i]; a write shows at +1, a read
    // word at +2, done at +2 after the last word.
    function automatic void build_expected(input bit mode, input logic [7:0] base, input bit full);
        expq.delete();
        for (int i = 0; i < rises.size(); i++) begin
            if (mode) begin
                ref_mem[i] = base + 8'(i);
                expq.push_back('{rises[i] + 1, 2'd1, 8'(i), ref_mem[i]});
            end else begin
                expq.push_back('{rises[i] + 2, 2'd2, 8'h00, ref_mem[i]});
            end
        end
        if (full) expq.push_back('{rises[rises.size()-1] + 2, 2'd3, 8'h00, 8'h00});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input int h, input int l, input bit glitch);
        rises.push_back(cyc);
        step_i = 1'b1;
        repeat (h) tick();
        step_i = 1'b0;
        if (glitch) begin
            start_i = 1'b1;
            mode_i  = ~mode_i;
            wdata_i = 8'($urandom);
            tick();
            start_i = 1'b0;
            repeat (l - 1) tick();
        end else begin
            repeat (l) tick();
        end
    endtask

    task automatic run_words(input int n, input bit rnd, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            if (rnd) drive_word(int'($urandom_range(1, 4)), int'($urandom_range(2, 5)), i == glitch_at);
            else     drive_word(4, 4, i == glitch_at);
        end
    endtask

    task automatic do_start(input bit mode, input logic [7:0] base);
        obs.delete();
        rises.delete();
        mode_i  = mode;
        wdata_i = base;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL start_busy got %b exp 1", busy_o);
        end
    endtask

    task automatic do_preload();
        preload = 1'b1;
        for (int i = 0; i < NW; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        tick();
        preload = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step_i = 1'b1;
        repeat (3) tick();
        obs.delete();
        rst_ni = 1'b1;
        for (int i = 0; i < 50; i++) begin
            n_vec++;
            if ({ram_bus.ram_we_o, ram_bus.ram_addr_o, ram_bus.ram_wdata_o, data_o, valid_o, busy_o, done_o} !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d got we=%b addr=%h wd=%h d=%h v=%b busy=%b done=%b exp all 0",
                         i, ram_bus.ram_we_o, ram_bus.ram_addr_o, ram_bus.ram_wdata_o, data_o, valid_o, busy_o, done_o);
            end
            tick();
        end
        step_i = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (obs.size() != 0) begin
            n_err++;
            $display("FAIL reset_events got %0d exp 0", obs.size());
        end
    endtask

    task automatic test_write_fill();
        do_start(1'b1, 8'hF8);
        run_words(NW, 1'b0, -1);
        repeat (4) tick();
        build_expected(1'b1, 8'hF8, 1'b1);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL fill_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL fill_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
        n_vec++;
        if ({busy_o, ram_bus.ram_addr_o} !== 5'b0) begin
            n_err++;
            $display("FAIL fill_end got busy=%b addr=%h exp 0/0", busy_o, ram_bus.ram_addr_o);
        end
    endtask

    task automatic test_read_scan();
        do_preload();
        do_start(1'b0, 8'($urandom));
        run_words(NW, 1'b1, -1);
        repeat (4) tick();
        build_expected(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL scan_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL scan_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL scan_end_busy got %b exp 0", busy_o);
        end
    endtask

    task automatic test_abort();
        logic [7:0] base;
        base = 8'($urandom);
        do_start(1'b1, base);
        run_words(5, 1'b1, -1);
        // Abort lands on the very tick of word 5; that write must not happen.
        step_i  = 1'b1;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_vec++;
        if ({busy_o, ram_bus.ram_we_o, ram_bus.ram_addr_o} !== 6'b0) begin
            n_err++;
            $display("FAIL abort_state got busy=%b we=%b addr=%h exp 0/0/0", busy_o, ram_bus.ram_we_o, ram_bus.ram_addr_o);
        end
        repeat (2) tick();
        step_i = 1'b0;
        repeat (3) tick();
        step_i = 1'b1;
        repeat (2) tick();
        step_i = 1'b0;
        repeat (3) tick();
        build_expected(1'b1, base, 1'b0);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL abort_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL abort_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
        // The following read pass shows the partial fill and starts at 0.
        do_start(1'b0, 8'h00);
        run_words(NW, 1'b1, -1);
        repeat (4) tick();
        build_expected(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL post_abort_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL post_abort_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
    endtask

    task automatic test_start_ignored();
        do_start(1'b0, 8'h33);
        run_words(NW, 1'b1, 7);
        repeat (4) tick();
        build_expected(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL busy_start_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL busy_start_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
        // start together with abort in IDLE must leave the block idle.
        obs.delete();
        mode_i  = 1'b1;
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_busy got %b exp 0", busy_o);
        end
        run_words(2, 1'b1, -1);
        rises.delete();
        n_vec++;
        if (obs.size() != 0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_idle got events=%0d busy=%b exp 0/0", obs.size(), busy_o);
        end
    endtask

    task automatic test_reset_mid();
        do_start(1'b0, 8'h00);
        run_words(9, 1'b1, -1);
        step_i = 1'b1;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({ram_bus.ram_we_o, ram_bus.ram_addr_o, ram_bus.ram_wdata_o, data_o, valid_o, busy_o, done_o} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got we=%b addr=%h wd=%h d=%h v=%b busy=%b done=%b exp all 0",
                     ram_bus.ram_we_o, ram_bus.ram_addr_o, ram_bus.ram_wdata_o, data_o, valid_o, busy_o, done_o);
        end
        build_expected(1'b0, 8'h00, 1'b0);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL mid_reset_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL mid_reset_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
        step_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        do_start(1'b0, 8'h00);
        run_words(NW, 1'b1, -1);
        repeat (4) tick();
        build_expected(1'b0, 8'h00, 1'b1);
        n_vec++;
        if (obs.size() != expq.size()) begin
            n_err++;
            $display("FAIL after_reset_count got %0d exp %0d", obs.size(), expq.size());
        end
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            n_vec++;
            if (obs[i] !== expq[i]) begin
                n_err++;
                $display("FAIL after_reset_ev[%0d] got %s exp %s", i, ev_str(obs[i]), ev_str(expq[i]));
            end
        end
    endtask

    task automatic test_random_passes();
        for (int p = 0; p < 4; p++) begin
            bit         mode;
            logic [7:0] base;
            mode = 1'($urandom);
            base = 8'($urandom);
            do_start(mode, base);
            run_words(NW, 1'b1, -1);
            repeat (4) tick();
            build_expected(mode, base, 1'b1);
            n_vec++;
            if (obs.size() != expq.size()) begin
                n_err++;
                $display("FAIL rand_count[%0d] got %0d exp %0d", p, obs.size(), expq.size());
            end
            for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
                n_vec++;
                if (obs[i] !== expq[i]) begin
                    n_err++;
                    $display("FAIL rand_ev[%0d][%0d] got %s exp %s", p, i, ev_str(obs[i]), ev_str(expq[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_fill();
        test_read_scan();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_random_passes();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
